// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default bit timing and small helpers.
// Used by both uart_rx and uart_tx.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } rx_state_t;

    localparam int CLOCKS_PER_BIT_DEF = 16;
    localparam int MID                = CLOCKS_PER_BIT_DEF / 2;
    localparam int CNT_W              = $clog2(CLOCKS_PER_BIT_DEF);

    function automatic int mid_of(input int clocksPerBit);
        return clocksPerBit / 2;
    endfunction

    function automatic int cnt_w_of(input int clocksPerBit);
        return $clog2(clocksPerBit);
    endfunction

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through byte FIFO for the UART receiver; a push into a full FIFO
// without a simultaneous pop is dropped and flagged with a one-cycle overrun pulse.
module uart_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     ready_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     valid_o,
    output logic                     overrun_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE   = (AW + 1)'(1);
    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      wr_ptr_d;
    logic [AW:0]      rd_ptr_q;
    logic [AW:0]      rd_ptr_d;
    logic [AW:0]      count;
    logic             overrun_q;
    logic             overrun_d;
    logic             full;
    logic             empty;
    logic             pop;
    logic             push_ok;

    // Pointers carry one extra bit so a full FIFO is distinguishable from an empty one.
    assign count   = wr_ptr_q - rd_ptr_q;
    assign full    = (count == DEPTH_CNT);
    assign empty   = (count == '0);
    assign pop     = !empty && ready_i;
    assign push_ok = push_i && (!full || pop);

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        overrun_d = 1'b0;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (push_i && !push_ok) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            overrun_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            overrun_q <= overrun_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= data_i;
        end
    end

    // The head is forced to zero while empty so stale storage never leaks out.
    assign data_o    = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    assign valid_o   = !empty;
    assign overrun_o = overrun_q;
    assign count_o   = count;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: two-flop input sync, 3-sample majority vote per bit and a frame FSM feeding
// an FWFT byte FIFO. Define UART_RX_PARITY_EN to expect an even-parity bit before the stop bit.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLOCKS_PER_BIT = 16,
    parameter int DATA_BITS      = 8,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          uart_data,
    output logic [DATA_BITS-1:0]          byte_in,
    output logic                          byte_valid,
    input  logic                          byte_ready,
    output logic                          framing_error,
    output logic                          overrun_error,
    output logic                          parity_error,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int RX_MID   = mid_of(CLOCKS_PER_BIT);
    localparam int RX_CNT_W = cnt_w_of(CLOCKS_PER_BIT);
    localparam int BIT_W    = $clog2(DATA_BITS + 1);

    localparam logic [RX_CNT_W-1:0] CNT_ONE   = RX_CNT_W'(1);
    localparam logic [RX_CNT_W-1:0] CNT_MIDM1 = RX_CNT_W'(RX_MID - 1);
    localparam logic [RX_CNT_W-1:0] CNT_MID   = RX_CNT_W'(RX_MID);
    localparam logic [RX_CNT_W-1:0] CNT_MIDP1 = RX_CNT_W'(RX_MID + 1);
    localparam logic [RX_CNT_W-1:0] CNT_LAST  = RX_CNT_W'(CLOCKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]    BIT_ONE   = BIT_W'(1);
    localparam logic [BIT_W-1:0]    BIT_LAST  = BIT_W'(DATA_BITS - 1);

    logic                 sync1_q;
    logic                 rx_s_q;
    rx_state_t            state_q;
    logic [RX_CNT_W-1:0]  cnt_q;
    logic [RX_CNT_W-1:0]  cnt_d;
    logic [BIT_W-1:0]     bit_idx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [1:0]           vote_q;
    logic                 bit_d;
    logic                 push_q;
    logic                 ferr_q;
`ifdef UART_RX_PARITY_EN
    logic                 par_bad_q;
    logic                 perr_q;
`endif

    always_ff @(posedge clock) begin
        if (!reset) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
        end else begin
            sync1_q <= uart_data;
            rx_s_q  <= sync1_q;
        end
    end

    // cnt_q is the position inside the current bit period, so MID lands on the bit centre.
    assign cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_ONE;
    assign bit_d = majority3(vote_q[0], vote_q[1], rx_s_q);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            vote_q    <= '0;
            push_q    <= 1'b0;
            ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            push_q <= 1'b0;
            ferr_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q <= 1'b0;
`endif
            if (state_q == DATA || state_q == PARITY || state_q == STOP) begin
                if (cnt_q == CNT_MIDM1) begin
                    vote_q[0] <= rx_s_q;
                end
                if (cnt_q == CNT_MID) begin
                    vote_q[1] <= rx_s_q;
                end
            end

            case (state_q)
                // The detecting edge is position 0 of the start bit, hence the load of one.
                IDLE: begin
                    if (!rx_s_q) begin
                        state_q <= START;
                        cnt_q   <= CNT_ONE;
                    end
                end
                START: begin
                    cnt_q <= cnt_d;
                    if (cnt_q == CNT_MID && rx_s_q) begin
                        state_q <= IDLE;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q   <= DATA;
                        bit_idx_q <= '0;
`ifdef UART_RX_PARITY_EN
                        par_bad_q <= 1'b0;
`endif
                    end
                end
                DATA: begin
                    cnt_q <= cnt_d;
                    if (cnt_q == CNT_MIDP1) begin
                        shift_q <= {bit_d, shift_q[DATA_BITS-1:1]};
                    end
                    if (cnt_q == CNT_LAST) begin
                        if (bit_idx_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_q <= PARITY;
`else
                            state_q <= STOP;
`endif
                        end else begin
                            bit_idx_q <= bit_idx_q + BIT_ONE;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    cnt_q <= cnt_d;
                    if (cnt_q == CNT_MIDP1) begin
                        par_bad_q <= bit_d ^ (^shift_q);
                    end
                    if (cnt_q == CNT_LAST) begin
                        state_q <= STOP;
                    end
                end
`endif
                // Decide at the centre of the stop bit and return to IDLE at once,
                // leaving the rest of the stop bit for resync on back-to-back frames.
                STOP: begin
                    cnt_q <= cnt_d;
                    if (cnt_q == CNT_MIDP1) begin
                        if (bit_d) begin
                            state_q <= IDLE;
`ifdef UART_RX_PARITY_EN
                            if (par_bad_q) begin
                                perr_q <= 1'b1;
                            end else begin
                                push_q <= 1'b1;
                            end
`else
                            push_q  <= 1'b1;
`endif
                        end else begin
                            ferr_q  <= 1'b1;
                            state_q <= BREAK;
                        end
                    end
                end
                BREAK: begin
                    if (rx_s_q) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    uart_rx_fifo #(
        .WIDTH(DATA_BITS),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .push_i   (push_q),
        .data_i   (shift_q),
        .ready_i  (byte_ready),
        .data_o   (byte_in),
        .valid_o  (byte_valid),
        .overrun_o(overrun_error),
        .count_o  (fifo_count)
    );

    assign framing_error = ferr_q;
`ifdef UART_RX_PARITY_EN
    assign parity_error = perr_q;
`else
    assign parity_error = 1'b0;
`endif

endmodule
